// File: rtl/program_loader.sv
// UART-fed program loader: reads a little-endian word count, streams that many
// little-endian words into instruction BRAM, then sends a one-byte acknowledge.
module program_loader #(
    parameter int          WORD_ADDR = 0,
    parameter int          MAX_WORDS = 16384,
    parameter logic [7:0]  ACK_OK    = 8'hAA,
    parameter logic [7:0]  ACK_ERR   = 8'h55
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] wreq_waddr,
    output logic [31:0] wreq_wdata,
    output logic        wreq_wenable,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [2:0] S_SIZE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ACK  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    logic [2:0]  state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] size_q, size_d;
    logic [31:0] index_q, index_d;
    logic        err_q, err_d;
    logic        wen_q, wen_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic [31:0] word_c;
    logic        last_c;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        size_d     = size_q;
        index_d    = index_q;
        err_d      = err_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        tx_data_d  = tx_data_q;
        // Bytes shift in from the top, so after four the first byte sits in bits 7:0.
        word_c     = {rx_data, shift_q};
        last_c     = (index_q == size_q - 32'd1);

        case (state_q)
            S_SIZE: begin
                if (rx_valid) begin
                    shift_d    = word_c[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (word_c == 32'd0) begin
                            state_d   = S_ACK;
                            err_d     = 1'b0;
                            tx_data_d = ACK_OK;
                        end else if (word_c > MAX_W) begin
                            state_d   = S_ACK;
                            err_d     = 1'b1;
                            tx_data_d = ACK_ERR;
                        end else begin
                            state_d = S_LOAD;
                            size_d  = word_c;
                            index_d = 32'd0;
                        end
                    end
                end
            end
            S_LOAD: begin
                if (wen_q) begin
                    index_d = index_q + 32'd1;
                end
                // The write strobe cycle stays in LOAD; a byte here starts the next word.
                if (wen_q && last_c) begin
                    state_d   = S_ACK;
                    err_d     = 1'b0;
                    tx_data_d = ACK_OK;
                end else if (rx_valid) begin
                    shift_d    = word_c[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wen_d   = 1'b1;
                        wdata_d = word_c;
                        waddr_d = (WORD_ADDR != 0) ? index_d : {index_d[29:0], 2'b00};
                    end
                end
            end
            S_ACK: begin
                if (!tx_busy) begin
                    state_d = err_q ? S_ERR : S_DONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_SIZE;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
            size_q     <= 32'd0;
            index_q    <= 32'd0;
            err_q      <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= 32'd0;
            wdata_q    <= 32'd0;
            tx_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            size_q     <= size_d;
            index_q    <= index_d;
            err_q      <= err_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign wreq_waddr   = waddr_q;
    assign wreq_wdata   = wdata_q;
    assign wreq_wenable = wen_q;
    assign tx_data      = tx_data_q;
    assign tx_start     = (state_q == S_ACK) && !tx_busy;
    assign load_done    = (state_q == S_DONE);
    assign load_err     = (state_q == S_ERR);

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter WORD_ADDR, default 0; 1 = waddr counts words, 0 = waddr counts bytes (index*4).
REQ-002 SHALL have parameter MAX_WORDS, default 16384; this is the instruction memory capacity in words.
REQ-003 SHALL have parameter ACK_OK, default 8'hAA; this is the byte sent after a successful load.
REQ-004 SHALL have parameter ACK_ERR, default 8'h55; this is the byte sent when the size is rejected.
REQ-005 SHALL have port clk, input, 1: single clock.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port rx_data, input, 8: byte from the UART receiver.
REQ-008 SHALL have port rx_valid, input, 1: one-cycle strobe marking rx_data valid.
REQ-009 SHALL have port wreq_waddr, output, 32: BRAM write address.
REQ-010 SHALL have port wreq_wdata, output, 32: BRAM write data.
REQ-011 SHALL have port wreq_wenable, output, 1: one-cycle BRAM write strobe.
REQ-012 SHALL have port tx_data, output, 8: ack byte to the UART transmitter.
REQ-013 SHALL have port tx_start, output, 1: one-cycle send strobe.
REQ-014 SHALL have port tx_busy, input, 1: transmitter busy.
REQ-015 SHALL have port load_done, output, 1: load finished successfully (sticky).
REQ-016 SHALL have port load_err, output, 1: size rejected (sticky).

Function
REQ-017 SHALL implement states SIZE, LOAD, ACK, DONE, ERR.
REQ-018 In SIZE, SHALL assemble 4 accepted bytes little-endian (first byte = bits 7:0) into word count N.
REQ-019 Byte assembly SHALL advance only on cycles with rx_valid=1; idle cycles between bytes have no effect.
REQ-020 After the 4th size byte: N=0 -> ACK (ok); N>MAX_WORDS -> ACK (err); otherwise -> LOAD with word index 0.
REQ-021 In LOAD, SHALL assemble 4 bytes little-endian per word.
REQ-022 On the cycle after the 4th byte of a word, SHALL assert wreq_wenable for exactly 1 cycle, with wdata = the word and waddr = index (WORD_ADDR=1) or index*4 (WORD_ADDR=0).
REQ-023 Index SHALL increment after each write.
REQ-024 After write N-1, SHALL go to ACK (ok).
REQ-025 A byte arriving on the same cycle wenable is asserted SHALL be accepted as byte 0 of the next word (no byte loss).
REQ-026 In ACK, SHALL wait while tx_busy=1.
REQ-027 On the first cycle in ACK with tx_busy=0, SHALL pulse tx_start for 1 cycle with tx_data = ACK_OK or ACK_ERR, then go to DONE or ERR respectively.
REQ-028 In DONE, SHALL hold load_done=1; in ERR, SHALL hold load_err=1. Both states SHALL ignore rx_valid until reset.
REQ-029 wreq_wenable SHALL never be asserted outside LOAD, and at most N times per load.
REQ-030 wreq_waddr and wreq_wdata SHALL hold their last values when wenable=0.
REQ-031 The index counter SHALL be 32 bits; byte-address arithmetic is modulo 2^32 (no wrap possible within MAX_WORDS).

Reset
REQ-032 On rst=1 at a clock edge: state=SIZE; byte counter, index, and N cleared; wreq_waddr=0, wreq_wdata=0, wreq_wenable=0, tx_start=0, tx_data=0, load_done=0, load_err=0.
REQ-033 Reset mid-load SHALL abandon any partial word; already-issued writes are not undone.
REQ-034 rx_valid during a reset cycle SHALL be ignored.

Verification
REQ-035 Size 02 00 00 00, then bytes 78 56 34 12 EF BE AD DE, WORD_ADDR=0 -> writes (0, 0x12345678) and (4, 0xDEADBEEF), then tx_start with 0xAA, then load_done=1.
REQ-036 Same stream with WORD_ADDR=1 -> waddr 0 then 1.
REQ-037 Size 00 00 00 00 -> no wenable; ack 0xAA; load_done=1.
REQ-038 Size 01 40 00 00 (16385) -> no wenable; ack 0x55; load_err=1; further bytes ignored.
REQ-039 tx_busy=1 for 20 cycles at ACK entry -> tx_start fires on the first cycle tx_busy=0, exactly once.
REQ-040 rst after 6 of 8 data bytes, then a full 1-word stream -> single write to address 0 with the new word; no stale bytes.
